// File: rtl/flag_condition_unit.sv
// ============================================================================
// flag_condition_unit
// ----------------------------------------------------------------------------
// Architectural Z/N/C/V flag register plus a 4-bit branch-condition evaluator
// and a small flag save stack used across interrupt entry/exit. It sits
// between the ALU (which supplies result/carry/overflow) and the branch/PC
// logic (which consumes the registered condition result).
//
// Parameters
//   WIDTH   : ALU result width (>= 2)
//   DEPTH   : number of flag save stack entries (>= 1)
//   FORWARD : 1 = evaluation sees the flags being written this cycle,
//             0 = evaluation sees the registered flags
//
// Ports
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   alu_result          : ALU result used for Z and N
//   alu_carry           : ALU carry-out (1 = no borrow on subtract)
//   alu_overflow        : ALU signed overflow
//   flags_we            : load flags from the ALU inputs
//   eval_valid, cond    : evaluate condition code cond this cycle
//   result/result_valid : registered condition result and its 1-cycle strobe
//   flags               : registered {Z,N,C,V}
//   push, pop           : save / restore flags on the stack
//   stack_empty/full    : stack occupancy status
//   stack_err           : sticky overflow / underflow / push+pop conflict
// ============================================================================
module flag_condition_unit #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int FORWARD = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             flags_we,
    input  logic             eval_valid,
    input  logic [3:0]       cond,
    output logic             result,
    output logic             result_valid,
    output logic [3:0]       flags,
    input  logic             push,
    input  logic             pop,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             stack_err
);

    // Depth counter must be able to hold the value DEPTH itself.
    localparam int DW = $clog2(DEPTH + 1);

    logic [3:0]    r_flags;
    logic [DW-1:0] r_depth;
    logic          r_err;
    logic          r_result;
    logic          r_result_valid;
    // Sized to the full index range so r_depth can address it directly;
    // entries at DEPTH and above are never written.
    logic [3:0]    r_stack [0:(2**DW)-1];

    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic          w_err;
    logic [DW-1:0] w_top_idx;
    logic [3:0]    w_alu_flags;
    logic [3:0]    w_next_flags;
    logic [3:0]    w_eval_flags;
    logic          w_z, w_n, w_c, w_v, w_lt;
    logic          w_cond_true;

    assign w_full    = (r_depth == DW'(DEPTH));
    assign w_empty   = (r_depth == '0);
    assign w_top_idx = r_depth - DW'(1);

    // A simultaneous push and pop is treated as a conflict: neither happens.
    assign w_push_ok = push & ~pop & ~w_full;
    assign w_pop_ok  = pop & ~push & ~w_empty;
    assign w_err     = (push & pop) | (push & w_full) | (pop & w_empty);

    assign w_alu_flags = {(alu_result == '0), alu_result[WIDTH-1],
                          alu_carry, alu_overflow};

    // Restore from the stack beats a fresh ALU write.
    always_comb begin
        w_next_flags = r_flags;
        if (w_pop_ok)
            w_next_flags = r_stack[w_top_idx];
        else if (flags_we)
            w_next_flags = w_alu_flags;
    end

    assign w_eval_flags = (FORWARD != 0) ? w_next_flags : r_flags;

    assign w_z  = w_eval_flags[3];
    assign w_n  = w_eval_flags[2];
    assign w_c  = w_eval_flags[1];
    assign w_v  = w_eval_flags[0];
    assign w_lt = w_n ^ w_v;

    always_comb begin
        w_cond_true = 1'b0;
        case (cond)
            4'b0000: w_cond_true = 1'b0;
            4'b0001: w_cond_true = w_z;
            4'b0010: w_cond_true = w_lt;
            4'b0011: w_cond_true = w_z | w_lt;
            4'b0100: w_cond_true = 1'b1;
            4'b0101: w_cond_true = ~w_z;
            4'b0110: w_cond_true = ~w_z & ~w_lt;
            4'b0111: w_cond_true = ~w_lt;
            4'b1000: w_cond_true = w_v;
            4'b1001: w_cond_true = ~w_c;
            4'b1010: w_cond_true = ~w_c | w_z;
            4'b1011: w_cond_true = w_n;
            4'b1100: w_cond_true = ~w_v;
            4'b1101: w_cond_true = w_c;
            4'b1110: w_cond_true = w_c & ~w_z;
            4'b1111: w_cond_true = ~w_n;
            default: w_cond_true = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_flags        <= 4'b0000;
            r_depth        <= '0;
            r_err          <= 1'b0;
            r_result       <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_flags <= w_next_flags;
            if (w_push_ok)
                r_depth <= r_depth + DW'(1);
            else if (w_pop_ok)
                r_depth <= w_top_idx;
            if (w_err)
                r_err <= 1'b1;
            r_result_valid <= eval_valid;
            if (eval_valid)
                r_result <= w_cond_true;
        end
    end

    // Stack storage needs no reset: depth = 0 makes old contents unreachable.
    always_ff @(posedge clock) begin
        if (!reset && w_push_ok)
            r_stack[r_depth] <= r_flags;
    end

    assign flags        = r_flags;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign stack_empty  = w_empty;
    assign stack_full   = w_full;
    assign stack_err    = r_err;

endmodule

// File: tb/tb_flag_condition_unit.sv
module tb_flag_condition_unit;

    localparam int W = 8;
    localparam int D = 4;

    logic         clock = 1'b0;
    logic         reset, alu_carry, alu_overflow, flags_we, eval_valid, push, pop;
    logic [W-1:0] alu_result;
    logic [3:0]   cond;
    logic         result, result_valid, stack_empty, stack_full, stack_err;
    logic [3:0]   flags;
    logic         result0, result_valid0, stack_empty0, stack_full0, stack_err0;
    logic [3:0]   flags0;

    always #5 clock = ~clock;

    flag_condition_unit #(.WIDTH(W), .DEPTH(D), .FORWARD(1)) dut (
        .clock(clock), .reset(reset), .alu_result(alu_result),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow), .flags_we(flags_we),
        .eval_valid(eval_valid), .cond(cond), .result(result),
        .result_valid(result_valid), .flags(flags), .push(push), .pop(pop),
        .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
    );

    flag_condition_unit #(.WIDTH(W), .DEPTH(D), .FORWARD(0)) dut0 (
        .clock(clock), .reset(reset), .alu_result(alu_result),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow), .flags_we(flags_we),
        .eval_valid(eval_valid), .cond(cond), .result(result0),
        .result_valid(result_valid0), .flags(flags0), .push(push), .pop(pop),
        .stack_empty(stack_empty0), .stack_full(stack_full0), .stack_err(stack_err0)
    );

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [3:0] m_flags;
    logic [3:0] m_stack[$];
    logic       m_err, m_res1, m_res0, m_rv;

    // Truth table of the condition codes written from named flag meanings.
    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic z, n, cy, v, signed_less;
        z = f[3]; n = f[2]; cy = f[1]; v = f[0];
        signed_less = (n != v);
        if (c == 4'd0)  return 1'b0;
        if (c == 4'd1)  return z;
        if (c == 4'd2)  return signed_less;
        if (c == 4'd3)  return z || signed_less;
        if (c == 4'd4)  return 1'b1;
        if (c == 4'd5)  return !z;
        if (c == 4'd6)  return !z && !signed_less;
        if (c == 4'd7)  return !signed_less;
        if (c == 4'd8)  return v;
        if (c == 4'd9)  return !cy;
        if (c == 4'd10) return !cy || z;
        if (c == 4'd11) return n;
        if (c == 4'd12) return !v;
        if (c == 4'd13) return cy;
        if (c == 4'd14) return cy && !z;
        return !n;
    endfunction

    task automatic model_step();
        logic [3:0] nf, alu;
        int sz;
        if (reset) begin
            m_flags = 4'b0; m_stack.delete(); m_err = 0;
            m_res1 = 0; m_res0 = 0; m_rv = 0;
            return;
        end
        sz  = m_stack.size();
        alu = {alu_result == 0, alu_result[W-1], alu_carry, alu_overflow};
        nf  = m_flags;
        if (push && pop) m_err = 1;
        else if (push && sz == D) m_err = 1;
        else if (pop && sz == 0) m_err = 1;
        if (pop && !push && sz > 0) nf = m_stack.pop_back();
        else if (flags_we) nf = alu;
        if (push && !pop && sz < D) m_stack.push_back(m_flags);
        m_rv = eval_valid;
        if (eval_valid) begin
            m_res1 = cond_ref(cond, nf);
            m_res0 = cond_ref(cond, m_flags);
        end
        m_flags = nf;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        check("model_flags", {flags, flags0}, {m_flags, m_flags});
        check("model_result", {6'b0, result, result0}, {6'b0, m_res1, m_res0});
        check("model_valid", {6'b0, result_valid, result_valid0}, {6'b0, m_rv, m_rv});
        check("model_stack", {2'b0, stack_empty, stack_full, stack_err,
                              stack_empty0, stack_full0, stack_err0},
              {2'b0, m_stack.size() == 0, m_stack.size() == D, m_err,
               m_stack.size() == 0, m_stack.size() == D, m_err});
    endtask

    task automatic idle();
        reset = 0; flags_we = 0; eval_valid = 0; push = 0; pop = 0;
        alu_result = '0; alu_carry = 0; alu_overflow = 0; cond = 4'h0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic rst, we; logic [7:0] res; logic c, v, ev; logic [3:0] cd;
        logic ps, pp;
        logic [3:0] x_flags; logic x_res, x_res0, x_rv, x_empty, x_full, x_err;
    } vec_t;

    function automatic vec_t mk(input logic rst, we, input logic [7:0] res,
                                input logic c, v, ev, input logic [3:0] cd,
                                input logic ps, pp, input logic [3:0] xf,
                                input logic xr, xr0, xrv, xe, xfu, xer);
        vec_t t;
        t.rst = rst; t.we = we; t.res = res; t.c = c; t.v = v; t.ev = ev;
        t.cd = cd; t.ps = ps; t.pp = pp; t.x_flags = xf; t.x_res = xr;
        t.x_res0 = xr0; t.x_rv = xrv; t.x_empty = xe; t.x_full = xfu; t.x_err = xer;
        return t;
    endfunction

    vec_t tbl[22];

    initial begin
        tbl[0]  = mk(1,0,8'h00,0,0,0,4'd0, 0,0, 4'b0000,0,0,0,1,0,0);
        tbl[1]  = mk(0,0,8'h00,0,0,1,4'd4, 0,0, 4'b0000,1,1,1,1,0,0);
        tbl[2]  = mk(0,1,8'h80,0,1,0,4'd0, 0,0, 4'b0101,1,1,0,1,0,0);
        tbl[3]  = mk(0,0,8'h00,0,0,1,4'd2, 0,0, 4'b0101,0,0,1,1,0,0);
        tbl[4]  = mk(0,0,8'h00,0,0,1,4'd7, 0,0, 4'b0101,1,1,1,1,0,0);
        tbl[5]  = mk(0,0,8'h00,0,0,1,4'd9, 0,0, 4'b0101,1,1,1,1,0,0);
        tbl[6]  = mk(0,1,8'h00,0,0,1,4'd1, 0,0, 4'b1000,1,0,1,1,0,0);
        tbl[7]  = mk(0,0,8'h00,0,0,0,4'd0, 1,0, 4'b1000,1,0,0,0,0,0);
        tbl[8]  = mk(0,1,8'h80,0,0,0,4'd0, 0,0, 4'b0100,1,0,0,0,0,0);
        tbl[9]  = mk(0,0,8'h00,0,0,0,4'd0, 0,1, 4'b1000,1,0,0,1,0,0);
        tbl[10] = mk(0,0,8'h00,0,0,0,4'd0, 1,0, 4'b1000,1,0,0,0,0,0);
        tbl[11] = mk(0,1,8'h01,1,0,1,4'd1, 0,1, 4'b1000,1,1,1,1,0,0);
        tbl[12] = mk(0,1,8'hFF,1,0,1,4'd14,0,0, 4'b0110,1,0,1,1,0,0);
        tbl[13] = mk(0,0,8'h00,0,0,1,4'd10,0,0, 4'b0110,0,0,1,1,0,0);
        tbl[14] = mk(0,0,8'h00,0,0,1,4'd3, 0,0, 4'b0110,1,1,1,1,0,0);
        tbl[15] = mk(0,0,8'h00,0,0,1,4'd8, 0,0, 4'b0110,0,0,1,1,0,0);
        tbl[16] = mk(0,0,8'h00,0,0,1,4'd12,0,0, 4'b0110,1,1,1,1,0,0);
        tbl[17] = mk(0,0,8'h00,0,0,1,4'd0, 0,0, 4'b0110,0,0,1,1,0,0);
        tbl[18] = mk(0,0,8'h00,0,0,1,4'd6, 0,0, 4'b0110,0,0,1,1,0,0);
        tbl[19] = mk(0,0,8'h00,0,0,1,4'd5, 0,0, 4'b0110,1,1,1,1,0,0);
        tbl[20] = mk(0,0,8'h00,0,0,1,4'd15,0,0, 4'b0110,0,0,1,1,0,0);
        tbl[21] = mk(0,0,8'h00,0,0,1,4'd11,0,0, 4'b0110,1,1,1,1,0,0);

        idle();
        reset = 1;

        for (int i = 0; i < 22; i++) begin
            reset = tbl[i].rst; flags_we = tbl[i].we; alu_result = tbl[i].res;
            alu_carry = tbl[i].c; alu_overflow = tbl[i].v; eval_valid = tbl[i].ev;
            cond = tbl[i].cd; push = tbl[i].ps; pop = tbl[i].pp;
            cycle();
            check($sformatf("vec%0d_flags", i), {4'b0, flags}, {4'b0, tbl[i].x_flags});
            check($sformatf("vec%0d_res", i), {6'b0, result, result0},
                  {6'b0, tbl[i].x_res, tbl[i].x_res0});
            check($sformatf("vec%0d_valid", i), {7'b0, result_valid}, {7'b0, tbl[i].x_rv});
            check($sformatf("vec%0d_stack", i), {5'b0, stack_empty, stack_full, stack_err},
                  {5'b0, tbl[i].x_empty, tbl[i].x_full, tbl[i].x_err});
        end

        // Overflow then underflow of the stack; error sticks until reset.
        idle();
        for (int i = 0; i < 5; i++) begin
            push = 1;
            cycle();
            check($sformatf("push%0d_full", i), {7'b0, stack_full}, {7'b0, i >= 3});
            check($sformatf("push%0d_err", i), {7'b0, stack_err}, {7'b0, i == 4});
        end
        push = 0;
        for (int i = 0; i < 5; i++) begin
            pop = 1;
            cycle();
            check($sformatf("pop%0d_empty", i), {7'b0, stack_empty}, {7'b0, i >= 3});
            check($sformatf("pop%0d_err", i), {7'b0, stack_err}, 8'd1);
            check($sformatf("pop%0d_flags", i), {4'b0, flags}, 8'b0110);
        end
        idle();
        cycle();
        check("err_sticky", {7'b0, stack_err}, 8'd1);
        reset = 1;
        cycle();
        check("err_cleared", {6'b0, stack_err, stack_empty}, 8'b01);

        // Push/pop conflict at depth 2.
        idle();
        flags_we = 1; alu_result = 8'h80; alu_overflow = 1; cycle();   // 0101
        idle(); push = 1; cycle();
        idle(); flags_we = 1; cycle();                                // 1000
        idle(); push = 1; cycle();
        idle(); push = 1; pop = 1; cycle();
        check("conflict_flags", {4'b0, flags}, 8'b1000);
        check("conflict_stat", {5'b0, stack_empty, stack_full, stack_err}, 8'b001);
        idle(); push = 1; pop = 1; flags_we = 1; alu_result = 8'h80; alu_carry = 1;
        cycle();
        check("conflict_we", {4'b0, flags}, 8'b0110);
        idle(); pop = 1; cycle();
        check("depth2_pop1", {3'b0, flags, stack_empty}, {3'b0, 4'b1000, 1'b0});
        idle(); pop = 1; cycle();
        check("depth2_pop2", {3'b0, flags, stack_empty}, {3'b0, 4'b0101, 1'b1});

        // Reset in the middle of activity.
        idle(); push = 1; flags_we = 1; alu_result = 8'h01; eval_valid = 1; cond = 4'd4;
        cycle();
        reset = 1; cycle();
        check("midreset", {result, result_valid, flags, stack_empty, stack_full},
              {1'b0, 1'b0, 4'b0000, 1'b1, 1'b0});
        check("midreset_err", {7'b0, stack_err}, 8'd0);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 99) == 0);
            flags_we     = $urandom_range(0, 1);
            eval_valid   = $urandom_range(0, 1);
            cond         = 4'($urandom_range(0, 15));
            push         = ($urandom_range(0, 3) == 0);
            pop          = ($urandom_range(0, 3) == 0);
            alu_carry    = $urandom_range(0, 1);
            alu_overflow = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0: alu_result = 8'h00;
                1: alu_result = 8'h80;
                default: alu_result = 8'($urandom_range(0, 255));
            endcase
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/flag_condition_unit.md
Name: flag_condition_unit

Overview:
- Parametrised successor to the 3-bit opcode/operand condition evaluator.
- Holds an architectural Z/N/C/V flag register, written from ALU results.
- Evaluates a 4-bit condition code against the flags, covering signed, unsigned and overflow conditions.
- Includes a DEPTH-entry flag save stack for interrupt entry/exit; sits between the ALU and the branch/PC logic.

Parameters:
- WIDTH, 8: ALU result width in bits (>= 2).
- DEPTH, 4: flag save stack entries (>= 1, power of two not required).
- FORWARD, 1: 1 = an evaluation sees the flags being written in the same cycle; 0 = it sees the registered flags.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- alu_result  in  WIDTH  ALU result for flag generation
- alu_carry  in  1  ALU carry-out (subtract as A+~B+1: 1 means no borrow)
- alu_overflow  in  1  ALU signed overflow
- flags_we  in  1  load flags from the ALU inputs
- eval_valid  in  1  evaluate cond this cycle
- cond  in  4  condition code
- result  out  1  registered condition result
- result_valid  out  1  one-cycle strobe qualifying result
- flags  out  4  {Z,N,C,V}, registered
- push  in  1  save current flags to stack
- pop  in  1  restore flags from stack
- stack_empty  out  1  depth == 0
- stack_full  out  1  depth == DEPTH
- stack_err  out  1  sticky overflow/underflow/conflict error

Behaviour:
- Reset (synchronous, active-high) has priority over all other inputs. It clears:
  - flags = 0, result = 0, result_valid = 0
  - depth = 0 (so stack_empty = 1, stack_full = 0)
  - stack_err = 0
- A reset mid-operation discards the stack contents and any evaluation in flight.
- Flag generation when flags_we = 1:
  - Z = (alu_result == 0)
  - N = alu_result[WIDTH-1]
  - C = alu_carry
  - V = alu_overflow
- Next-flags source, in priority order:
  1. valid pop: flags <= top-of-stack.
  2. flags_we: flags <= ALU-derived flags.
  3. otherwise: flags hold.
- A valid pop and flags_we in the same cycle: pop wins and the ALU flags are dropped.
- Condition codes (lt = N^V):
  - 0000 never
  - 0001 Z
  - 0010 lt
  - 0011 Z|lt
  - 0100 always
  - 0101 !Z
  - 0110 !Z & !lt
  - 0111 !lt
  - 1000 V
  - 1001 !C (ltu)
  - 1010 !C|Z (leu)
  - 1011 N
  - 1100 !V
  - 1101 C (geu)
  - 1110 C&!Z (gtu)
  - 1111 !N
- Codes 0000-0111 keep the previous generation's semantics for a compare-against-zero result.
- Evaluation latency is 1 cycle. When eval_valid is high at edge k:
  - result and result_valid = 1 appear after edge k.
  - FORWARD = 1: the evaluation uses next-flags (including a pop in that cycle).
  - FORWARD = 0: the evaluation uses the registered flags.
- When eval_valid is low at edge k: result_valid = 0 after edge k and result holds its last value.
- There is no backpressure; back-to-back evaluations yield back-to-back strobes.
- Stack:
  - push stores the current registered flags (pre-update) at index depth, then depth+1.
  - pop loads stack[depth-1], then depth-1.
  - push together with flags_we: the old flags are pushed and the new flags are loaded.
- Stack boundary conditions:
  - push when full: ignored, stack_err <= 1.
  - pop when empty: ignored, flags follow flags_we or hold, stack_err <= 1.
  - push and pop in the same cycle: both ignored, stack_err <= 1, and flags_we still applies.
- stack_err is sticky; only reset clears it.
- stack_full and stack_empty are derived from the registered depth.

Test Plan:
- Reset, then eval cond=0100 -> result_valid=1 and result=1 one cycle later; flags=0000 and stack_empty=1.
- WIDTH=8:
  - flags_we with alu_result=8'h80, carry=0, ovf=1 -> flags N=1, V=1, lt=0.
  - cond 0010 -> 0.
  - cond 0111 -> 1.
  - cond 1001 -> 1.
- FORWARD=1, flags_we with alu_result=0 and eval cond=0001 in the same cycle -> result=1 next cycle. With FORWARD=0 and prior flags Z=0 -> result=0.
- Push flags 1000, then flags_we to 0100, then pop -> flags return to 1000. A pop simultaneous with flags_we -> stacked value wins.
- DEPTH=4: five pushes -> stack_full after the 4th; 5th sets stack_err=1 and depth stays 4. Four pops then a 5th -> stack_empty=1 and stack_err stays 1 until reset.
- push and pop asserted together at depth 2 -> depth stays 2, flags unchanged, stack_err=1. Assert reset mid-sequence -> all outputs at their reset values on the next cycle.
